dl_router: RTL and testbench

Parametrised ROM-download router between `hps_io`'s ioctl stream and the SDRAM write ports. It decodes byte writes into up to four ROM regions and gathers bytes into `WORD_BYTES`-wide words with byte enables. Words are buffered in a small FIFO and issued over a toggle req/ack handshake. The block also captures the game-mode byte (ioctl index 1) and sequences `rom_loaded` and the post-download game reset, replacing per-core hand-written offset/interleave logic.

---
 rtl/dl_router.sv | 222 ++++++++++++++++++++++
 tb/tb_dl_router.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dl_router                                                     |
// | Purpose  : Routes the hps_io ioctl byte stream into SDRAM write words.   |
// |            Decodes bytes into up to four ROM regions and gathers them    |
// |            into WORD_BYTES-wide words with byte enables. Queues words in |
// |            a small FIFO and issues them over a toggle req/ack handshake. |
// |            Also captures the mode byte (index 1) and sequences           |
// |            rom_loaded and the post-download game reset.                  |
// | Ports    : clk_sys, reset_n (sync, active-low)                           |
// |            ioctl_download/wr/addr/dout/index in, ioctl_wait out          |
// |            out_req/out_region/out_addr/out_data/out_be out, out_ack in   |
// |            mode, rom_loaded, game_reset out                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dl_router #(
  parameter int                 WORD_BYTES = 4,
  parameter int                 NREG       = 3,
  parameter logic [NREG*25-1:0] REG_BASE   = {25'h32000, 25'h12000, 25'h0},
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [15:0]        RESET_HOLD = 16'hFFFF
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  input  logic [7:0]              ioctl_index,
  output logic                    ioctl_wait,
  output logic                    out_req,
  input  logic                    out_ack,
  output logic [1:0]              out_region,
  output logic [22:0]             out_addr,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]   out_be,
  output logic [7:0]              mode,
  output logic                    rom_loaded,
  output logic                    game_reset
);

  localparam int SH = $clog2(WORD_BYTES);
  localparam int LW = (SH > 0) ? SH : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 + 23 + 8*WORD_BYTES + WORD_BYTES;
  localparam logic [PW:0]           FULL_LVL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]           WAIT_LVL = (PW+1)'(FIFO_DEPTH - 1);
  localparam logic [WORD_BYTES-1:0] BE_ONE   = 1;
  localparam logic [LW-1:0]         LAST_LANE = LW'(WORD_BYTES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // ---------------------------------------------------------------- decode
  logic        hit;
  logic [1:0]  wr_region;
  logic [24:0] offset;
  logic [22:0] wr_waddr;
  logic [LW-1:0] wr_lane;

  // Bases are ascending, so the last base not above the address wins.
  always_comb begin
    hit       = 1'b0;
    wr_region = '0;
    offset    = '0;
    for (int r = 0; r < NREG; r++) begin
      if (ioctl_addr >= REG_BASE[r*25 +: 25]) begin
        hit       = 1'b1;
        wr_region = 2'(r);
        offset    = ioctl_addr - REG_BASE[r*25 +: 25];
      end
    end
  end

  assign wr_waddr = 23'(offset >> SH);

  generate
    if (SH > 0) begin : g_lane
      assign wr_lane = offset[LW-1:0];
    end else begin : g_lane_single
      assign wr_lane = '0;
    end
  endgenerate

  logic rom_wr, mode_wr;
  assign rom_wr  = ioctl_download & ioctl_wr & (ioctl_index == 8'd0) & hit;
  assign mode_wr = ioctl_download & ioctl_wr & (ioctl_index == 8'd1);

  // ---------------------------------------------------------------- gather
  logic                    buf_valid, buf_full, dl_q;
  logic [8*WORD_BYTES-1:0] buf_data;
  logic [WORD_BYTES-1:0]   buf_be;
  logic [1:0]              buf_region;
  logic [22:0]             buf_addr;
  logic                    match, flush;

  assign match = buf_valid & (buf_region == wr_region) & (buf_addr == wr_waddr);
  // buf_full is the pending flag: the last lane was written last cycle, so
  // the word goes out now. Every push source empties the same buffer, so at
  // most one push happens per cycle.
  assign flush = buf_valid & (buf_full | (dl_q & ~ioctl_download) | (rom_wr & ~match));

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      buf_valid  <= 1'b0;
      buf_full   <= 1'b0;
      buf_be     <= '0;
      buf_data   <= '0;
      buf_region <= '0;
      buf_addr   <= '0;
    end else begin
      if (flush) begin
        buf_valid <= 1'b0;
        buf_full  <= 1'b0;
        buf_be    <= '0;
      end
      if (rom_wr) begin
        buf_valid  <= 1'b1;
        buf_region <= wr_region;
        buf_addr   <= wr_waddr;
        buf_full   <= (wr_lane == LAST_LANE);
        if (flush || !buf_valid) begin
          // Fresh word: unwritten lanes are don't-care (their enables are 0).
          buf_be   <= BE_ONE << wr_lane;
          buf_data <= {WORD_BYTES{ioctl_dout}};
        end else begin
          buf_be                  <= buf_be | (BE_ONE << wr_lane);
          buf_data[wr_lane*8 +: 8] <= ioctl_dout;
        end
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;
  logic          pop, accept;
  state_t        state;

  assign pop    = (state == BUSY) && (out_ack == out_req);
  // A push into a full FIFO (no pop this cycle) is dropped.
  assign accept = flush && ((count != FULL_LVL) || pop);

  always_comb begin
    count_next = count;
    if (accept && !pop)      count_next = count + 1'b1;
    else if (!accept && pop) count_next = count - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (accept) mem[wr_ptr] <= {buf_region, buf_addr, buf_data, buf_be};
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      ioctl_wait <= (count_next >= WAIT_LVL);
    end
  end

  // ---------------------------------------------------------------- issue
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      out_req    <= out_ack;  // abandon any outstanding request silently
      out_region <= '0;
      out_addr   <= '0;
      out_data   <= '0;
      out_be     <= '0;
    end else begin
      case (state)
        IDLE: if (count != '0) begin
          {out_region, out_addr, out_data, out_be} <= mem[rd_ptr];
          out_req <= ~out_req;
          state   <= BUSY;
        end
        BUSY: if (out_ack == out_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- load / reset
  logic        dl_seen, load_done;
  logic [15:0] hold_cnt;

  // dl_seen keeps an idle block coming out of reset from claiming a load
  // that never happened.
  assign load_done = dl_seen & ~ioctl_download & ~buf_valid & ~buf_full &
                     (count == '0) & (state == IDLE);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dl_q       <= 1'b0;
      dl_seen    <= 1'b0;
      mode       <= '0;
      rom_loaded <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (ioctl_download) dl_seen <= 1'b1;
      if (mode_wr)        mode    <= ioctl_dout;
      if (load_done && !rom_loaded) begin
        rom_loaded <= 1'b1;
        hold_cnt   <= RESET_HOLD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign game_reset = ~rom_loaded | ioctl_download | (hold_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_dl_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dl_router                                                  |
// | Purpose  : Self-checking bench for dl_router. Instance A uses the        |
// |            default geometry (RESET_HOLD=16), instance B uses             |
// |            WORD_BYTES=1, NREG=2. Expected words are queued as stimulus   |
// |            is driven and compared as the DUT issues them.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dl_router;

  typedef struct {
    logic [1:0]  region;
    logic [22:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic        ioctl_download, ioctl_wr, ioctl_wait, out_req, out_ack;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index, mode;
  logic [1:0]  out_region;
  logic [22:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        rom_loaded, game_reset;

  // Instance B signals
  logic        b_download, b_wr, b_wait, b_req, b_ack, b_loaded, b_greset;
  logic [24:0] b_addr;
  logic [7:0]  b_dout, b_index, b_mode, b_data;
  logic [1:0]  b_region;
  logic [22:0] b_oaddr;
  logic [0:0]  b_be;

  dl_router #(.RESET_HOLD(16'd16)) dut_a (
    .clk_sys(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .out_req(out_req), .out_ack(out_ack), .out_region(out_region), .out_addr(out_addr),
    .out_data(out_data), .out_be(out_be), .mode(mode), .rom_loaded(rom_loaded),
    .game_reset(game_reset)
  );

  dl_router #(.WORD_BYTES(1), .NREG(2), .REG_BASE({25'h1000, 25'h0100}),
              .RESET_HOLD(16'd16)) dut_b (
    .clk_sys(clk), .reset_n(reset_n),
    .ioctl_download(b_download), .ioctl_wr(b_wr), .ioctl_addr(b_addr),
    .ioctl_dout(b_dout), .ioctl_index(b_index), .ioctl_wait(b_wait),
    .out_req(b_req), .out_ack(b_ack), .out_region(b_region), .out_addr(b_oaddr),
    .out_data(b_data), .out_be(b_be), .mode(b_mode), .rom_loaded(b_loaded),
    .game_reset(b_greset)
  );

  int   checks = 0;
  int   errors = 0;
  int   got_words = 0;
  exp_t sb[$];
  exp_t e;
  logic mon_en = 1'b0;
  logic ack_auto = 1'b1;
  logic seen_req = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // Monitor + acknowledger for instance A
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_req !== seen_req) begin
        seen_req = out_req;
        got_words++;
        if (sb.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = sb.pop_front();
          check("region", out_region, e.region);
          check("addr", out_addr, e.addr);
          check("be", out_be, e.be);
          check("data", out_data & bmask(out_be), e.data & bmask(e.be));
        end
      end else if (ack_auto && out_ack !== out_req) begin
        out_ack = out_req;
      end
    end
  end

  task automatic push_exp(input logic [1:0] r, input logic [22:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    exp_t x;
    x.region = r; x.addr = a; x.data = d; x.be = be;
    sb.push_back(x);
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (ioctl_wait && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("wait_timeout", 1, 0);
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_req !== out_ack) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  task automatic wr_b(input logic [24:0] a, input logic [7:0] d, input logic exp_hit,
                      input logic [1:0] r, input logic [22:0] wa);
    int n = 0;
    @(negedge clk);
    b_addr = a; b_dout = d; b_wr = 1'b1;
    @(negedge clk);
    b_wr = 1'b0;
    while (b_req === b_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_req_toggle", b_req !== b_ack, exp_hit);
    if (exp_hit) begin
      check("b_region", b_region, r);
      check("b_addr", b_oaddr, wa);
      check("b_data", b_data, d);
      check("b_be", b_be, 1);
      b_ack = b_req;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n, base, toggles;
    logic r0;
    logic [31:0] w;
    reset_n = 1'b0;
    ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
    out_ack = 1'b0;
    b_download = 0; b_wr = 0; b_addr = '0; b_dout = '0; b_index = '0; b_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_wait", ioctl_wait, 0);
    check("rst_req", out_req, 0);
    check("rst_outs", {out_region, out_addr, out_data, out_be}, 0);
    check("rst_mode", mode, 0);
    check("rst_loaded", rom_loaded, 0);
    check("rst_greset", game_reset, 1);

    reset_n = 1'b1;
    seen_req = out_req;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_not_loaded", rom_loaded, 0);
    ioctl_download = 1'b1;

    // Full-word gather into region 1
    push_exp(2'd1, 23'd0, 32'h44332211, 4'hF);
    wr_byte(8'd0, 25'h12000, 8'h11);
    wr_byte(8'd0, 25'h12001, 8'h22);
    wr_byte(8'd0, 25'h12002, 8'h33);
    wr_byte(8'd0, 25'h12003, 8'h44);
    wait_drain();

    // Mode bytes; other indices ignored
    wr_byte(8'd1, 25'h0, 8'h02);
    wr_byte(8'd1, 25'h0, 8'h03);
    wr_byte(8'd2, 25'h12000, 8'h99);
    repeat (10) @(negedge clk);
    check("mode", mode, 8'h03);

    // Partial flush on address jump, then on download fall
    push_exp(2'd0, 23'd1, 32'h0000AA00, 4'b0010);
    wr_byte(8'd0, 25'h5, 8'hAA);
    push_exp(2'd0, 23'h10, 32'h000000BB, 4'b0001);
    wr_byte(8'd0, 25'h40, 8'hBB);
    check("greset_in_dl", game_reset, 1);
    check("not_loaded_buffered", rom_loaded, 0);
    ioctl_download = 1'b0;
    n = 0;
    while (!rom_loaded && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rom_loaded", rom_loaded, 1);
    check("drained_at_load", sb.size(), 0);
    n = 0;
    while (game_reset && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_cycles", n, 16);
    check("mode_kept", mode, 8'h03);

    // Backpressure: ack held static while 32 bytes stream in
    ioctl_download = 1'b1;
    ack_auto = 1'b0;
    base = got_words;
    @(negedge clk);
    check("greset_redl", game_reset, 1);
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          if (i % 4 == 3) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((i - 3 + k) * 7 + 1);
            push_exp(2'd1, 23'(i / 4), w, 4'hF);
          end
          wr_byte(8'd0, 25'h12000 + 25'(i), 8'(i * 7 + 1));
        end
      end
      begin
        int m = 0;
        while (!ioctl_wait && m < 1000) begin
          @(negedge clk);
          m++;
        end
        check("wait_rise", ioctl_wait, 1);
        check("words_at_wait", got_words - base, 1);
        repeat (20) @(negedge clk);
        check("wait_held", ioctl_wait, 1);
        ack_auto = 1'b1;
      end
    join
    wait_drain();
    check("bp_words", got_words - base, 8);
    ioctl_download = 1'b0;
    repeat (5) @(negedge clk);

    // Reset while BUSY with an outstanding request
    ioctl_download = 1'b1;
    ack_auto = 1'b0;
    base = got_words;
    push_exp(2'd2, 23'd0, 32'h0D0C0B0A, 4'hF);
    for (int i = 0; i < 4; i++) wr_byte(8'd0, 25'h32000 + 25'(i), 8'h0A + 8'(i));
    n = 0;
    while (got_words == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_issued", got_words - base, 1);
    check("req_outstanding", out_req !== out_ack, 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_req", out_req, out_ack);
    check("mid_rst_loaded", rom_loaded, 0);
    check("mid_rst_greset", game_reset, 1);
    check("mid_rst_wait", ioctl_wait, 0);
    check("mid_rst_mode", mode, 0);
    r0 = out_req;
    toggles = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_req !== r0) toggles++;
    end
    check("no_toggle", toggles, 0);
    check("still_not_loaded", rom_loaded, 0);
    seen_req = out_req;
    mon_en = 1'b1;
    ack_auto = 1'b1;

    // WORD_BYTES=1, NREG=2 instance
    b_download = 1'b1;
    @(negedge clk);
    wr_b(25'h0105, 8'h5C, 1'b1, 2'd0, 23'h5);
    wr_b(25'h1003, 8'hC3, 1'b1, 2'd1, 23'h3);
    wr_b(25'h0FFF, 8'h7E, 1'b1, 2'd0, 23'hEFF);
    wr_b(25'h0040, 8'h11, 1'b0, 2'd0, 23'h0);
    check("b_no_wait", b_wait, 0);
    check("a_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
